// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG sequencing controller: state encoding and
// counter-width helpers.
package trng_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WARMUP  = 3'd1;
  localparam state_t S_COLLECT = 3'd2;
  localparam state_t S_HOLD    = 3'd3;
  localparam state_t S_FAIL    = 3'd4;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Warm-up counter runs 0..cycles-1.
  function automatic int warm_w(input int cycles);
    return cnt_w(cycles);
  endfunction

  // Divider counter runs 0..div-1.
  function automatic int div_w(input int div);
    return cnt_w(div);
  endfunction

  // Bit counter runs 0..width-1.
  function automatic int bit_w(input int width);
    return cnt_w(width);
  endfunction

  // Repetition counter must be able to reach the limit itself.
  function automatic int rep_w(input int limit);
    return cnt_w(limit + 1);
  endfunction

endpackage

// File: rtl/trng_if.sv
// Word delivery channel from the TRNG controller to the bus-side register file.
interface trng_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  word_valid;
  logic                  word_ready;
  logic [WORD_WIDTH-1:0] word_data;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/trng_sync2.sv
// Standard two-flop synchronizer cell for a single asynchronous bit.
module trng_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make meta and q update together at the
    // edge; blocking ones would collapse the two stages into one.
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs samples, emits the first bit of 01/10 pairs and
// drops 00/11. In raw mode every sample is passed straight through.
module trng_vn_debias (
  input  logic clk,
  input  logic reset,
  input  logic sample_stb,
  input  logic raw_bit,
  input  logic mode,
  input  logic clear,
  output logic accept_stb,
  output logic accept_bit
);
  logic phase;
  logic first_bit;

  // Pair phase and first-of-pair capture
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase     <= 1'b0;
      first_bit <= 1'b0;
    end else if (sample_stb && mode) begin
      phase <= ~phase;
      if (!phase) first_bit <= raw_bit;
    end
  end

  // Decide whether the current sample yields an output bit
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    accept_stb = 1'b0;
    accept_bit = raw_bit;
    if (!mode) begin
      accept_stb = sample_stb;
    end else if (phase) begin
      accept_stb = sample_stb && (raw_bit != first_bit);
      accept_bit = first_bit;
    end
  end
endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencing controller: warm-up, divided sampling, optional debiasing,
// repetition-count health test and word packing onto a valid/ready channel.
module trng_ctrl
  import trng_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     enable,
  input  logic     debias_en,
  output logic     trng_en,
  input  logic     trng_bit,
  trng_if.master   word_if,
  output logic     health_fail,
  output logic     busy
);
  localparam int WARM_W = warm_w(WARMUP_CYCLES);
  localparam int DIV_W  = div_w(SAMPLE_DIV);
  localparam int BIT_W  = bit_w(WORD_WIDTH);
  localparam int REP_W  = rep_w(REP_LIMIT);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
  localparam logic [REP_W-1:0]  REP_TRIP  = REP_W'(REP_LIMIT);

  state_t                state;
  logic [WARM_W-1:0]     warm_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [REP_W-1:0]      rep_cnt;
  logic [REP_W-1:0]      run_next;
  logic                  last_raw;
  logic                  mode;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  raw;
  logic                  sample_stb;
  logic                  acc_stb;
  logic                  acc_bit;
  logic                  trip;
  logic                  word_done;

  trng_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (trng_bit),
    .q     (raw)
  );

  trng_vn_debias u_debias (
    .clk        (clk),
    .reset      (reset),
    .sample_stb (sample_stb),
    .raw_bit    (raw),
    .mode       (mode),
    .clear      (state != S_COLLECT && state != S_HOLD),
    .accept_stb (acc_stb),
    .accept_bit (acc_bit)
  );

  assign sample_stb = (state == S_COLLECT) && (div_cnt == DIV_LAST);
  assign trip       = sample_stb && (run_next == REP_TRIP);
  assign word_done  = acc_stb && (bit_cnt == BIT_LAST);

  // Run length the repetition test would hold after the current sample
  always_comb begin
    run_next = REP_W'(1);
    if (rep_cnt != '0 && raw == last_raw) run_next = rep_cnt + 1'b1;
  end

  // Sequencer, counters and word shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      warm_cnt <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      last_raw <= 1'b0;
      mode     <= 1'b0;
      // NOTE: shreg is reset because it drives word_data straight onto the
      // bus; purely internal data storage would not need a reset.
      shreg    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          shreg <= '0;
          if (enable) begin
            state    <= S_WARMUP;
            mode     <= debias_en;
            warm_cnt <= '0;
            rep_cnt  <= '0;
          end
        end
        S_WARMUP: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (warm_cnt == WARM_LAST) begin
            state   <= S_COLLECT;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        S_COLLECT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (sample_stb) begin
              last_raw <= raw;
              rep_cnt  <= run_next;
              if (trip) begin
                state <= S_FAIL;
              end else if (acc_stb) begin
                shreg <= {shreg[WORD_WIDTH-2:0], acc_bit};
                if (word_done) begin
                  state   <= S_HOLD;
                  bit_cnt <= '0;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (word_if.word_ready) begin
            state   <= S_COLLECT;
            div_cnt <= '0;
          end
        end
        S_FAIL: begin
          if (!enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign trng_en            = (state == S_WARMUP) || (state == S_COLLECT) || (state == S_HOLD);
  assign busy               = trng_en;
  assign health_fail        = (state == S_FAIL);
  assign word_if.word_valid = (state == S_HOLD);
  assign word_if.word_data  = shreg;

endmodule

// File: tb/tb_trng_ctrl.sv
// Self-checking bench for trng_ctrl: directed scenarios with literal
// expectations plus a randomized soak, all compared every cycle against a
// behavioural model built from queues and countdowns.
module tb_trng_ctrl;
  localparam int W   = 8;
  localparam int WU  = 16;
  localparam int DIV = 2;
  localparam int REP = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic debias_en = 1'b0;
  logic trng_bit = 1'b0;
  logic trng_en, health_fail, busy;

  trng_if #(.WORD_WIDTH(W)) wif ();

  trng_ctrl #(
    .WORD_WIDTH    (W),
    .WARMUP_CYCLES (WU),
    .SAMPLE_DIV    (DIV),
    .REP_LIMIT     (REP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .debias_en   (debias_en),
    .trng_en     (trng_en),
    .trng_bit    (trng_bit),
    .word_if     (wif),
    .health_fail (health_fail),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_WARM, M_COLL, M_HOLD, M_FAIL} mph_t;
  mph_t   m_ph = M_IDLE;
  bit     m_live = 1'b0;
  bit     m_just_reset = 1'b0;
  bit     m_s1 = 1'b0, m_s2 = 1'b0;
  bit     m_deb = 1'b0;
  bit     have_first = 1'b0, first = 1'b0, last = 1'b0;
  int     warm_left = 0, wait_left = 0, run = 0;
  int     m_data = 0;
  bit     acc[$];

  always @(posedge clk) begin : model
    bit r;
    int v;
    r = m_s2;          // raw sample is the value two input edges old
    m_s2 = m_s1;
    m_s1 = trng_bit;
    m_just_reset = 1'b0;
    if (reset) begin
      m_ph = M_IDLE; m_s1 = 0; m_s2 = 0; m_data = 0; acc.delete();
      m_just_reset = 1'b1; m_live = 1'b1;
    end else begin
      case (m_ph)
        M_IDLE: if (enable) begin
          m_ph = M_WARM; warm_left = WU; m_deb = debias_en;
          run = 0; have_first = 0; acc.delete();
        end
        M_WARM: if (!enable) m_ph = M_IDLE;
                else begin
                  warm_left--;
                  if (warm_left == 0) begin m_ph = M_COLL; wait_left = DIV; end
                end
        M_COLL: if (!enable) m_ph = M_IDLE;
                else begin
                  wait_left--;
                  if (wait_left == 0) begin
                    wait_left = DIV;
                    run = (run > 0 && r == last) ? run + 1 : 1;
                    last = r;
                    if (run >= REP) m_ph = M_FAIL;
                    else begin
                      if (!m_deb) acc.push_back(r);
                      else if (!have_first) begin first = r; have_first = 1; end
                      else begin have_first = 0; if (r != first) acc.push_back(first); end
                      if (acc.size() == W) begin
                        v = 0;
                        foreach (acc[i]) v = v * 2 + int'(acc[i]);
                        m_data = v; acc.delete(); m_ph = M_HOLD;
                      end
                    end
                  end
                end
        M_HOLD: if (!enable) m_ph = M_IDLE;
                else if (wif.word_ready) begin m_ph = M_COLL; wait_left = DIV; end
        M_FAIL: if (!enable) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (m_live) begin
      bit on;
      on = (m_ph == M_WARM) || (m_ph == M_COLL) || (m_ph == M_HOLD);
      check("trng_en", trng_en, on);
      check("busy", busy, on);
      check("word_valid", wif.word_valid, m_ph == M_HOLD);
      check("health_fail", health_fail, m_ph == M_FAIL);
      if (m_ph == M_HOLD) check("word_data", wif.word_data, m_data);
      if (m_just_reset) check("reset_word_data", wif.word_data, 0);
    end
  end

  // ---------------- directed stimulus helpers ----------------
  bit pat [0:31];

  task automatic set_pat(input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) pat[k] = v[n-1-k];
  endtask

  // From IDLE: enable, then present pat[k] so that it is the k-th sample.
  // Returns #1 after the edge just before the n-th sample is taken.
  task automatic feed(input bit deb, input int n);
    debias_en = deb;
    enable = 1'b1;
    for (int j = 0; j < WU + DIV * n; j++) begin
      trng_bit = (j >= WU) ? pat[(j - WU) / DIV] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (j == 0) check("trng_en_rise", trng_en, 1);
      check("early_valid", wif.word_valid, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int stuck;
    wif.word_ready = 1'b0;
    repeat (3) tick();
    check("rst_trng_en", trng_en, 0);
    check("rst_valid", wif.word_valid, 0);
    check("rst_data", wif.word_data, 0);
    check("rst_health", health_fail, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Raw mode first word: 1,0,1,0,... -> 8'hAA exactly WU+8*DIV after start
    set_pat(32'hAA, 8);
    feed(1'b0, 8);
    tick();
    check("first_valid", wif.word_valid, 1);
    check("first_data", wif.word_data, 32'hAA);

    // Backpressure: word must hold while ready is low
    for (int i = 0; i < 50; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      tick();
      check("bp_valid", wif.word_valid, 1);
      check("bp_data", wif.word_data, 32'hAA);
    end
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    check("hs_valid_drop", wif.word_valid, 0);
    check("hs_busy", busy, 1);
    n = 0;
    while (!wif.word_valid && n < 100) begin
      trng_bit = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("resume_latency", n, W * DIV);

    // Debias: pairs 01,10,11,00,10,01,10,01,01,10 -> 0,1,1,0,1,0,0,1
    enable = 1'b0;
    tick();
    check("abort_hold_busy", busy, 0);
    set_pat(32'h6C996, 20);
    feed(1'b1, 20);
    tick();
    check("debias_valid", wif.word_valid, 1);
    check("debias_data", wif.word_data, 32'h69);

    // Health: stuck-at-1 in debias mode yields no bits and trips at sample 32
    enable = 1'b0;
    tick();
    set_pat(32'hFFFF_FFFF, 32);
    feed(1'b1, 32);
    check("pre_trip_health", health_fail, 0);
    tick();
    check("trip_health", health_fail, 1);
    check("trip_trng_en", trng_en, 0);
    check("trip_busy", busy, 0);
    check("trip_valid", wif.word_valid, 0);
    repeat (5) tick();
    check("fail_sticky", health_fail, 1);
    enable = 1'b0;
    tick();
    check("fail_cleared", health_fail, 0);

    // Re-enable after failure repeats the full warm-up
    set_pat(32'hAA, 8);
    feed(1'b0, 8);
    tick();
    check("rewarm_valid", wif.word_valid, 1);
    check("rewarm_data", wif.word_data, 32'hAA);

    // Abort mid-collect after 5 bits, then a fresh full word
    enable = 1'b0;
    tick();
    set_pat(32'h1F, 5);
    feed(1'b0, 5);
    tick();
    enable = 1'b0;
    tick();
    check("abort_trng_en", trng_en, 0);
    check("abort_busy", busy, 0);
    set_pat(32'hCD, 8);
    feed(1'b0, 8);
    tick();
    check("fresh_valid", wif.word_valid, 1);
    check("fresh_data", wif.word_data, 32'hCD);

    // Synchronous reset while holding a word
    reset = 1'b1;
    #3;
    check("rst_between_edges", wif.word_valid, 1);
    @(posedge clk); #1;
    check("srst_valid", wif.word_valid, 0);
    check("srst_data", wif.word_data, 0);
    check("srst_trng_en", trng_en, 0);
    check("srst_busy", busy, 0);
    check("srst_health", health_fail, 0);
    reset = 1'b0;

    // Randomized soak against the model
    stuck = 0;
    for (int c = 0; c < 6000; c++) begin
      reset = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      debias_en = 1'($urandom_range(0, 1));
      if (stuck == 0 && $urandom_range(0, 599) == 0) stuck = 150;
      if (stuck > 0) begin
        trng_bit = 1'b1;
        stuck--;
      end else begin
        trng_bit = 1'($urandom_range(0, 1));
      end
      wif.word_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0;
    enable = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
- Sequencing controller for the ring-oscillator TRNG macro.
- Gates the oscillator enable and waits out a warm-up period.
- Samples the raw TRNG bit at a programmable divided rate, optionally von-Neumann debiases it, and runs a repetition-count health test.
- Packs accepted bits into words delivered over a valid/ready interface to the bus-side register file.

Parameters:
WORD_WIDTH, 32, bits per output word (≥2).
WARMUP_CYCLES, 256, clk cycles with trng_en high before the first sample is used (≥1).
SAMPLE_DIV, 4, clk cycles between raw samples (≥1).
REP_LIMIT, 32, consecutive identical raw samples that trip the health test (≥2).

Ports:
clk  input  1  system clock, also the sampling clock
reset  input  1  synchronous, active-high reset
enable  input  1  software enable for the generator
debias_en  input  1  1 = von Neumann debiasing, 0 = raw bits; sampled only in IDLE
trng_en  output  1  enable to the TRNG macro
trng_bit  input  1  raw TRNG output, asynchronous to clk
word_valid  output  1  word_data holds a complete word
word_ready  input  1  consumer accepts the word when word_valid && word_ready
word_data  output  WORD_WIDTH  assembled random word
health_fail  output  1  sticky health-test failure flag
busy  output  1  high in WARMUP, COLLECT or HOLD

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high.
- Reset values: trng_en=0, word_valid=0, word_data=0, health_fail=0, busy=0. State is IDLE; all counters are cleared.
- trng_bit passes through a 2-flop synchronizer. The raw sample is the second flop, read on the cycle the divider counter wraps (every SAMPLE_DIV cycles).
- IDLE:
  - trng_en=0.
  - When enable=1: latch debias_en, clear the warm-up counter, go to WARMUP.
- WARMUP:
  - trng_en=1; count WARMUP_CYCLES cycles.
  - At terminal count, go to COLLECT; the divider and bit counter start at 0.
  - The first sample is taken SAMPLE_DIV cycles after entering COLLECT.
- COLLECT:
  - trng_en=1.
  - Raw mode: every sample is accepted.
  - Debias mode: samples are paired (first, second). Pair 01 -> accept 0; pair 10 -> accept 1; pairs 00 and 11 are discarded.
  - Accepted bits shift into the LSB of the shift register (word_data <= {word_data[W-2:0], bit}).
  - When the WORD_WIDTH-th bit is accepted: word_valid is set on the next cycle; go to HOLD.
- HOLD:
  - trng_en stays 1 and sampling stops; the pair phase and repetition counter are frozen.
  - word_data is stable while word_valid=1.
  - On the handshake cycle, word_valid clears next cycle; return to COLLECT with the bit counter at 0.
  - No warm-up is repeated.
- Health test:
  - Operates on raw samples in both modes.
  - Tracks the run length of identical consecutive samples. Reaching REP_LIMIT -> FAIL.
- FAIL:
  - trng_en=0, word_valid=0, health_fail=1, busy=0.
  - Stays in FAIL until enable=0, which clears health_fail and returns to IDLE.
- enable=0 in WARMUP, COLLECT or HOLD:
  - Next cycle: IDLE, trng_en=0, word_valid=0.
  - The partial word and pair phase are discarded.
- Reset mid-operation: immediate return to reset values on the next edge, regardless of state or handshake.
- Simultaneous events:
  - Handshake and enable falling in the same cycle: the word counts as consumed; go to IDLE.
  - Health trip and the final word bit in the same sample: FAIL wins; the word is not presented.

Decomposition:
- trng_pkg holds:
  - the state enum (IDLE, WARMUP, COLLECT, HOLD, FAIL);
  - the counter-width helper functions (clog2-based) for the warm-up, divider, bit and repetition counters.
- Sub-module trng_vn_debias:
  - inputs: sample strobe, raw bit, mode, clear;
  - outputs: accept strobe and accepted bit;
  - owns the pair-phase flop.
- The synchronizer is the codebase's standard 2-flop cell.

Test Plan:
- Warm-up and first sample: W=8, WARMUP=16, DIV=2, raw mode, trng_bit toggling 1,0,1,0 per sample. trng_en rises 1 cycle after enable. First word_valid arrives 16 + 8*2 (+ sync latency) cycles later. word_data=8'b10101010 (or its complement, depending on the starting phase; check against the model).
- Debias: debias_en=1, pair stream 01,10,11,00,10 feeding W=4 -> accepted bits 0,1,1 then needs one more pair. Pairs 11 and 00 add no bits. Final word matches the model.
- Backpressure: word_ready=0 for 50 cycles. word_valid held, word_data constant, no new samples taken. Ready pulse -> valid drops next cycle and collection resumes without warm-up.
- Health fail: trng_bit stuck at 1, REP_LIMIT=32. health_fail=1 after the 32nd sample; trng_en=0; no word is emitted. enable=0 clears it; re-enable repeats the warm-up.
- Abort: deassert enable mid-COLLECT with 5 of 8 bits taken. IDLE next cycle. Re-enable produces a full fresh word with no stale bits.
- Sync reset: assert reset while in HOLD. All outputs are at reset values after the edge; reset is ignored between edges.
